// File: rtl/parade_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : parade_cmd_gen
//  Purpose  : Debounced operator front end that drives the P/R request
//             levels of the parade-mode FSM, waits for its M confirmation
//             and times the parade.
//  Revision : 1.0  initial release
// ============================================================================
module parade_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PARADE_CYCLES   = 16,
    parameter int ACK_TIMEOUT     = 8,
    parameter int CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start_btn,
    input  logic i_stop_btn,
    input  logic i_M,
    output logic o_P,
    output logic o_R,
    output logic o_busy,
    output logic o_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_REL  = 2'd3;

    localparam logic [CNT_W-1:0] c_db_full  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_ack_last = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_par_last = CNT_W'(PARADE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    // Bit 0 = start, bit 1 = stop
    logic [1:0] w_btn_raw;
    logic [1:0] w_evt;
    logic       w_start_evt;
    logic       w_stop_evt;

    assign w_btn_raw   = {i_stop_btn, i_start_btn};
    assign w_start_evt = w_evt[0];
    assign w_stop_evt  = w_evt[1];

    // The count saturates at the threshold so a held button keeps its level
    // without ever producing a second edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl_q;
        logic             r_evt;
        logic             w_lvl;

        assign w_lvl = (r_cnt == c_db_full);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_cnt   <= '0;
                r_lvl_q <= 1'b0;
                r_evt   <= 1'b0;
            end else begin
                if (!w_btn_raw[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_db_full) begin
                    r_cnt <= r_cnt + c_one;
                end
                r_lvl_q <= w_lvl;
                r_evt   <= w_lvl & ~r_lvl_q;
            end
        end

        assign w_evt[gi] = r_evt;
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_p;
    logic             r_r;
    logic             r_busy;
    logic             r_err;
    logic             w_p_nxt;
    logic             w_r_nxt;
    logic             w_busy_nxt;
    logic             w_err_nxt;
    logic             w_ack_to;
    logic             w_par_done;

    assign w_ack_to   = (r_cnt == c_ack_last);
    assign w_par_done = (r_cnt == c_par_last);

    // State register; outputs are registered alongside the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_p     <= 1'b0;
            r_r     <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p     <= w_p_nxt;
            r_r     <= w_r_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic; M checks take priority over the timers
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_evt && !w_stop_evt) begin
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                if (i_M) begin
                    w_state_nxt = c_RUN;
                end else if (w_ack_to) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RUN: begin
                if (!i_M) begin
                    w_state_nxt = c_IDLE;
                end else if (w_par_done || w_stop_evt) begin
                    w_state_nxt = c_REL;
                end
            end
            c_REL: begin
                if (!i_M || w_ack_to) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output / counter logic, evaluated against the upcoming state
    always_comb begin
        w_p_nxt    = (w_state_nxt == c_REQ);
        w_r_nxt    = (w_state_nxt == c_REL);
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_err_nxt  = r_err;
        w_cnt_nxt  = r_cnt;

        if (w_state_nxt != r_state || w_state_nxt == c_IDLE) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + c_one;
        end

        if (w_state_nxt == c_IDLE) begin
            case (r_state)
                c_REQ:   w_err_nxt = 1'b1;
                c_RUN:   w_err_nxt = 1'b1;
                c_REL:   w_err_nxt = i_M ? 1'b1 : r_err;
                default: w_err_nxt = r_err;
            endcase
        end else if (r_state == c_IDLE) begin
            w_err_nxt = 1'b0;
        end
    end

    assign o_P    = r_p;
    assign o_R    = r_r;
    assign o_busy = r_busy;
    assign o_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_parade_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parade_cmd_gen
//  Purpose  : Directed bench for parade_cmd_gen with a two-cycle mode-FSM
//             responder model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parade_cmd_gen;

    logic clk;
    logic rst;
    logic start_btn;
    logic stop_btn;
    logic m_q;
    logic o_P;
    logic o_R;
    logic o_busy;
    logic o_err;

    logic resp_en;
    logic m_kill;
    logic p_d;
    logic r_d;

    int n_tests;
    int n_fail;

    parade_cmd_gen #(
        .DEBOUNCE_CYCLES (4),
        .PARADE_CYCLES   (16),
        .ACK_TIMEOUT     (8),
        .CNT_W           (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start_btn (start_btn),
        .i_stop_btn  (stop_btn),
        .i_M         (m_q),
        .o_P         (o_P),
        .o_R         (o_R),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Mode FSM stand-in: registers P/R, then M follows two cycles later
    always @(posedge clk) begin
        if (rst) begin
            p_d <= 1'b0;
            r_d <= 1'b0;
            m_q <= 1'b0;
        end else begin
            p_d <= resp_en & o_P;
            r_d <= resp_en & o_R;
            if (m_kill)   m_q <= 1'b0;
            else if (p_d) m_q <= 1'b1;
            else if (r_d) m_q <= 1'b0;
        end
    end

    task automatic test_reset();
        logic [3:0] exp_v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_v = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL reset k=%0d got PRBE=%b exp %b", k, {o_P, o_R, o_busy, o_err}, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_normal();
        logic [3:0] exp_v;
        int e;
        for (int k = 0; k < 32; k++) begin
            start_btn = (k < 6);
            stop_btn  = 1'b0;
            @(negedge clk);
            e = k + 1;
            exp_v = {(e >= 6 && e <= 8), (e >= 25 && e <= 27), (e >= 6 && e <= 27), 1'b0};
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL normal e=%0d got PRBE=%b exp %b", e, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp_v;
        exp_v = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            start_btn = (k < 3);
            @(negedge clk);
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL glitch e=%0d got PRBE=%b exp %b", k + 1, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
    endtask

    task automatic test_stop();
        logic [3:0] exp_v;
        int e;
        for (int k = 0; k < 24; k++) begin
            start_btn = (k < 6);
            stop_btn  = (k >= 10 && k < 16);
            @(negedge clk);
            e = k + 1;
            exp_v = {(e >= 6 && e <= 8), (e >= 16 && e <= 18), (e >= 6 && e <= 18), 1'b0};
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL stop e=%0d got PRBE=%b exp %b", e, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
        stop_btn = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] exp_v;
        int e;
        resp_en = 1'b0;
        for (int k = 0; k < 18; k++) begin
            start_btn = (k < 6);
            @(negedge clk);
            e = k + 1;
            exp_v = {(e >= 6 && e <= 13), 1'b0, (e >= 6 && e <= 13), (e >= 14)};
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL timeout e=%0d got PRBE=%b exp %b", e, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
        resp_en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            start_btn = (k < 6);
            @(negedge clk);
            e = k + 1;
            exp_v = {(e >= 6 && e <= 8), (e >= 25 && e <= 27), (e >= 6 && e <= 27), (e < 6)};
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL recover e=%0d got PRBE=%b exp %b", e, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [3:0] exp_v;
        exp_v = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            start_btn = (k < 6);
            stop_btn  = (k < 6);
            @(negedge clk);
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL same_cycle e=%0d got PRBE=%b exp %b", k + 1, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
        stop_btn = 1'b0;
    endtask

    task automatic test_mode_drop();
        logic [3:0] exp_v;
        int e;
        for (int k = 0; k < 18; k++) begin
            start_btn = (k < 6);
            m_kill    = (k == 12);
            @(negedge clk);
            e = k + 1;
            exp_v = {(e >= 6 && e <= 8), 1'b0, (e >= 6 && e <= 13), (e >= 14)};
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL mode_drop e=%0d got PRBE=%b exp %b", e, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
        m_kill = 1'b0;
    endtask

    task automatic test_reset_clears_err();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({o_P, o_R, o_busy, o_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_err got PRBE=%b exp 0000", {o_P, o_R, o_busy, o_err});
        end
    endtask

    task automatic test_reset_in_rel();
        logic [3:0] exp_v;
        int e;
        for (int k = 0; k < 58; k++) begin
            start_btn = (k < 6) || (k >= 25);
            rst       = (k == 25);
            @(negedge clk);
            e = k + 1;
            if (e <= 25)
                exp_v = {(e >= 6 && e <= 8), (e == 25), (e >= 6), 1'b0};
            else
                exp_v = {(e >= 32 && e <= 34), (e >= 51 && e <= 53), (e >= 32 && e <= 53), 1'b0};
            n_tests++;
            if ({o_P, o_R, o_busy, o_err} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_rel e=%0d got PRBE=%b exp %b", e, {o_P, o_R, o_busy, o_err}, exp_v);
            end
        end
        rst       = 1'b0;
        start_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        resp_en   = 1'b1;
        m_kill    = 1'b0;
        n_tests   = 0;
        n_fail    = 0;

        test_reset();
        test_normal();
        test_glitch();
        test_stop();
        test_timeout();
        test_same_cycle();
        test_mode_drop();
        test_reset_clears_err();
        test_reset_in_rel();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parade_cmd_gen.md
Name: parade_cmd_gen

Overview:
- Command-side generator for the traffic-light parade-mode FSM.
- Debounces operator start/stop buttons and produces the P (enter parade) and R (release) request levels.
- Holds each request until the mode feedback M confirms it, and times the parade duration.
- Sits between the operator-panel inputs and the mode FSM; its o_P/o_R outputs drive that FSM's P/R inputs, and its i_M input is fed from that FSM's M output.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a button must read 1 before it counts as pressed.
- PARADE_CYCLES, 16: cycles spent in RUN before automatic release.
- ACK_TIMEOUT, 8: maximum cycles to wait for M to confirm a request.
- CNT_W, 8: width of the internal counters; must hold max(PARADE_CYCLES, ACK_TIMEOUT, DEBOUNCE_CYCLES).

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start_btn  input  1  raw operator start button, already synchronized.
- i_stop_btn  input  1  raw operator stop button, already synchronized.
- i_M  input  1  mode feedback from the mode FSM (1 = parade).
- o_P  output  1  parade request level to the mode FSM.
- o_R  output  1  release request level to the mode FSM.
- o_busy  output  1  high whenever the state is not IDLE.
- o_err  output  1  sticky handshake-failure flag.

Behaviour:
- Reset:
  - i_rst sampled high at a rising edge puts state in IDLE and clears all counters and debounce history.
  - o_P=0, o_R=0, o_busy=0, o_err=0 from the following cycle.
  - Reset asserted mid-operation aborts immediately, including while a request is held; no R is issued.
- Debounce (one instance per button):
  - A counter increments while the raw input is 1 and clears to 0 when it is 0.
  - The debounced level goes 1 when the count reaches DEBOUNCE_CYCLES.
  - An event is a one-cycle pulse on the debounced level's 0->1 edge.
  - Holding a button produces exactly one event. A glitch shorter than DEBOUNCE_CYCLES produces none.
- States: IDLE, REQ, RUN, REL. All outputs are registered.
- IDLE:
  - o_P=0, o_R=0.
  - A start event moves to REQ and clears o_err.
  - A stop event is ignored. If start and stop events occur in the same cycle, stop wins and the state stays IDLE.
- REQ:
  - o_P=1; a timeout counter runs from 0.
  - i_M==1 moves to RUN, and o_P drops on the next cycle.
  - If ACK_TIMEOUT cycles elapse without i_M==1: set o_err=1 and go to IDLE.
  - Start and stop events are ignored.
- RUN:
  - o_P=0, o_R=0; the parade counter runs from 0.
  - Moves to REL when the counter reaches PARADE_CYCLES-1 or a stop event occurs, whichever comes first.
  - If i_M falls to 0 while in RUN: set o_err=1 and go to IDLE without issuing R.
  - Start events are ignored.
- REL:
  - o_R=1; the timeout counter restarts.
  - i_M==0 moves to IDLE, and o_R drops on the next cycle.
  - Timeout after ACK_TIMEOUT cycles: set o_err=1 and go to IDLE.
- Output timing:
  - o_P and o_R are never both 1.
  - o_busy = (state != IDLE) and is registered together with the state.
- Latency: the mode FSM registers P/R internally, so i_M follows o_P by 2 cycles. ACK_TIMEOUT must be at least 3.
- Counter widths: counters saturate rather than wrap.

Test Plan:
- Start pressed 6 cycles, with the companion FSM model responding after 2 cycles:
  - o_P=1 at cycle 6 after the press begins (4 debounce cycles plus the edge and register stages).
  - o_P drops once i_M=1.
  - After 16 RUN cycles o_R=1 until i_M=0; o_busy then returns to 0, with o_err=0.
- 3-cycle start glitch: no event; o_P and o_busy stay 0.
- Stop pressed 5 RUN cycles into a parade: o_R asserts on the cycle after the stop event, before the 16-cycle timer expires; the sequence ends in IDLE.
- i_M held at 0 (responder absent): o_P=1 for exactly 8 cycles, then o_err=1, o_P=0, state IDLE. The next valid start clears o_err.
- Start and stop debounced events in the same IDLE cycle: no o_P, state stays IDLE.
- i_rst pulsed while in REL with o_R=1: next cycle o_R=0, o_busy=0, o_err=0. A held start button then produces a fresh event only after DEBOUNCE_CYCLES.
